// File: rtl/instruction_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_ram_pkg
// Description : Definitions shared with the CPU: instruction opcodes, the idle
//               instruction word and small helpers used by instruction_ram.
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_ram_pkg;

   // CPU opcode field (top nibble of a 28-bit instruction word)
   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_LOAD = 4'h1,
      OP_STORE= 4'h2,
      OP_ADD  = 4'h3,
      OP_SUB  = 4'h4,
      OP_JMP  = 4'h8,
      OP_BRZ  = 4'h9,
      OP_LED  = 4'hE,
      OP_HALT = 4'hF
   } opcode_t;

   // Word the CPU sees when no valid instruction is available
   localparam logic [27:0] IRAM_DEFAULT_WORD = {OP_LED, 24'b10101010};

   // Number of load bytes needed to build one instruction word
   function automatic int iram_bytes_per_word(input int width);
      return (width + 7) / 8;
   endfunction

endpackage : instruction_ram_pkg
`default_nettype wire

// File: rtl/iram_array.sv
`default_nettype none
// ============================================================================
// Module      : iram_array
// Description : Instruction storage, one write port and one registered read
//               port. Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module iram_array #(
   parameter int DATA_WIDTH = 28,
   parameter int DEPTH      = 256,
   parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [AW-1:0]         waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]         raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Write port: one word per cycle when enabled
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read port: address sampled every cycle, data available next cycle
   always_ff @(posedge clk_i) begin
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule : iram_array
`default_nettype wire

// File: rtl/instruction_ram.sv
`default_nettype none
// ============================================================================
// Module      : instruction_ram
// Description : CPU instruction memory with registered fetch and a byte-wise
//               program loader (IDLE -> COLLECT -> WRITE -> COLLECT/DONE).
//               Define IRAM_PARITY_EN to store an even-parity bit per word
//               and expose oParityError.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_ram
   import instruction_ram_pkg::*;
#(
   parameter int                    DATA_WIDTH   = 28,
   parameter int                    ADDR_WIDTH   = 16,
   parameter int                    DEPTH        = 256,
   parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = DATA_WIDTH'(IRAM_DEFAULT_WORD)
)(
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic [ADDR_WIDTH-1:0] iAddress,
   output logic [DATA_WIDTH-1:0] oInstruction,
   output logic                  oInstrValid,
   input  logic                  iLoadStart,
   input  logic [ADDR_WIDTH-1:0] iLoadBase,
   input  logic [ADDR_WIDTH-1:0] iLoadCount,
   input  logic [7:0]            iLoadByte,
   input  logic                  iLoadByteValid,
   output logic                  oLoadReady,
   output logic                  oLoadBusy,
   output logic                  oLoadDone,
   output logic                  oLoadError
`ifdef IRAM_PARITY_EN
   ,output logic                 oParityError
`endif
);

   localparam int NB     = iram_bytes_per_word(DATA_WIDTH);
   localparam int BCW    = (NB > 1) ? $clog2(NB) : 1;
   localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // One extra bit so the load address can step past the top without wrapping
   localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [BCW-1:0]      LAST_BYTE = BCW'(NB - 1);
`ifdef IRAM_PARITY_EN
   localparam int STORE_W = DATA_WIDTH + 1;
`else
   localparam int STORE_W = DATA_WIDTH;
`endif

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_WRITE   = 2'd2,
      S_DONE    = 2'd3
   } load_state_e;

   load_state_e             state_q, state_d;
   logic [ADDR_WIDTH:0]     addr_q, addr_d;
   logic [ADDR_WIDTH-1:0]   count_q, count_d;
   logic [BCW-1:0]          byte_cnt_q, byte_cnt_d;
   logic [DATA_WIDTH-1:0]   word_q, word_d;
   logic                    error_q, error_d;
   logic                    instr_valid_q, instr_valid_d;
   logic                    fetch_oor_q, fetch_oor_d;
   logic                    mem_we;
   logic [STORE_W-1:0]      mem_wdata;
   logic [STORE_W-1:0]      mem_rdata;

   // Load FSM state and fetch qualifiers
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q       <= S_IDLE;
         addr_q        <= '0;
         count_q       <= '0;
         byte_cnt_q    <= '0;
         word_q        <= '0;
         error_q       <= 1'b0;
         instr_valid_q <= 1'b0;
         fetch_oor_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         count_q       <= count_d;
         byte_cnt_q    <= byte_cnt_d;
         word_q        <= word_d;
         error_q       <= error_d;
         instr_valid_q <= instr_valid_d;
         fetch_oor_q   <= fetch_oor_d;
      end
   end

   // Next-state logic: byte assembly, word write and load bookkeeping
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      count_d    = count_q;
      byte_cnt_d = byte_cnt_q;
      word_d     = word_q;
      error_d    = error_q;
      mem_we     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (iLoadStart) begin
               if (iLoadCount != '0) begin
                  addr_d     = {1'b0, iLoadBase};
                  count_d    = iLoadCount;
                  byte_cnt_d = '0;
                  error_d    = 1'b0;
                  state_d    = S_COLLECT;
               end else begin
                  state_d    = S_DONE;
               end
            end
         end
         S_COLLECT: begin
            if (iLoadByteValid) begin
               // Shift in MSB-first; truncation drops surplus bits of byte 0
               word_d = DATA_WIDTH'({word_q, iLoadByte});
               if (byte_cnt_q == LAST_BYTE) begin
                  byte_cnt_d = '0;
                  state_d    = S_WRITE;
               end else begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
               end
            end
         end
         S_WRITE: begin
            if (addr_q >= DEPTH_EXT) begin
               // Out of range: drop the word and abandon the rest of the load
               error_d = 1'b1;
               state_d = S_DONE;
            end else begin
               mem_we  = 1'b1;
               addr_d  = addr_q + 1'b1;
               count_d = count_q - 1'b1;
               state_d = (count_q == ADDR_WIDTH'(1)) ? S_DONE : S_COLLECT;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // Fetch is usable only after a full cycle spent idle
      instr_valid_d = (state_q == S_IDLE) && (state_d == S_IDLE);
      fetch_oor_d   = ({1'b0, iAddress} >= DEPTH_EXT);
   end

`ifdef IRAM_PARITY_EN
   assign mem_wdata    = {^word_q, word_q};
   assign oParityError = instr_valid_q && !fetch_oor_q && (^mem_rdata);
`else
   assign mem_wdata    = word_q;
`endif

   iram_array #(
      .DATA_WIDTH (STORE_W),
      .DEPTH      (DEPTH),
      .AW         (MEM_AW)
   ) u_array (
      .clk_i   (Clock),
      .we_i    (mem_we),
      .waddr_i (addr_q[MEM_AW-1:0]),
      .wdata_i (mem_wdata),
      .raddr_i (iAddress[MEM_AW-1:0]),
      .rdata_o (mem_rdata)
   );

   assign oInstruction = (instr_valid_q && !fetch_oor_q) ? mem_rdata[DATA_WIDTH-1:0]
                                                         : DEFAULT_WORD;
   assign oInstrValid  = instr_valid_q;
   assign oLoadReady   = (state_q == S_COLLECT);
   assign oLoadBusy    = (state_q != S_IDLE);
   assign oLoadDone    = (state_q == S_DONE);
   assign oLoadError   = error_q;

endmodule : instruction_ram
`default_nettype wire

// File: tb/tb_instruction_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_ram
// Description : Directed self-checking bench for instruction_ram.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_ram;

   localparam logic [27:0] EXP_DEFAULT = 28'hE0000AA;

   logic        Clock;
   logic        Reset;
   logic [15:0] iAddress;
   logic [27:0] oInstruction;
   logic        oInstrValid;
   logic        iLoadStart;
   logic [15:0] iLoadBase;
   logic [15:0] iLoadCount;
   logic [7:0]  iLoadByte;
   logic        iLoadByteValid;
   logic        oLoadReady;
   logic        oLoadBusy;
   logic        oLoadDone;
   logic        oLoadError;
`ifdef IRAM_PARITY_EN
   logic        oParityError;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int d0;

   instruction_ram dut (
      .Clock          (Clock),
      .Reset          (Reset),
      .iAddress       (iAddress),
      .oInstruction   (oInstruction),
      .oInstrValid    (oInstrValid),
      .iLoadStart     (iLoadStart),
      .iLoadBase      (iLoadBase),
      .iLoadCount     (iLoadCount),
      .iLoadByte      (iLoadByte),
      .iLoadByteValid (iLoadByteValid),
      .oLoadReady     (oLoadReady),
      .oLoadBusy      (oLoadBusy),
      .oLoadDone      (oLoadDone),
      .oLoadError     (oLoadError)
`ifdef IRAM_PARITY_EN
      ,.oParityError  (oParityError)
`endif
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Count completion pulses, sampled mid-cycle
   always @(negedge Clock) begin
      if (oLoadDone === 1'b1) done_cnt = done_cnt + 1;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      iLoadByteValid = 1'b1;
      iLoadByte      = b;
      tick();
      iLoadByteValid = 1'b0;
   endtask

   // Four bytes MSB first, then the WRITE cycle
   task automatic send_word(input logic [31:0] w);
      send_byte(w[31:24]);
      send_byte(w[23:16]);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
      tick();
   endtask

   task automatic start_load(input logic [15:0] base, input logic [15:0] cnt);
      iLoadBase  = base;
      iLoadCount = cnt;
      iLoadStart = 1'b1;
      tick();
      iLoadStart = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"}, oInstrValid, 1'b0);
      chk({tag, "_instr"}, oInstruction, EXP_DEFAULT);
      chk({tag, "_ready"}, oLoadReady, 1'b0);
      chk({tag, "_busy"},  oLoadBusy, 1'b0);
      chk({tag, "_done"},  oLoadDone, 1'b0);
      chk({tag, "_error"}, oLoadError, 1'b0);
   endtask

   initial begin
      Reset = 1'b0; iAddress = '0; iLoadStart = 1'b0; iLoadBase = '0;
      iLoadCount = '0; iLoadByte = '0; iLoadByteValid = 1'b0;
      repeat (3) tick();
      chk_reset_outputs("por");

      // Out-of-range fetch right after reset release
      iAddress = 16'd300;
      Reset    = 1'b1;
      tick();
      chk("oor_valid", oInstrValid, 1'b1);
      chk("oor_instr", oInstruction, EXP_DEFAULT);

      // Two-word load at address 0, with a stray start mid-load
      d0 = done_cnt;
      iAddress = 16'd0;
      start_load(16'd0, 16'd2);
      chk("ld0_busy",  oLoadBusy, 1'b1);
      chk("ld0_ready", oLoadReady, 1'b1);
      chk("ld0_valid", oInstrValid, 1'b0);
      chk("ld0_instr", oInstruction, EXP_DEFAULT);
      iLoadStart = 1'b1; iLoadBase = 16'd100; iLoadCount = 16'd5;
      send_byte(8'h00);
      iLoadStart = 1'b0;
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h01);
      chk("ld0_write_ready", oLoadReady, 1'b0);
      chk("ld0_write_busy",  oLoadBusy, 1'b1);
      tick();
      send_word(32'h00000FA0);
      chk("ld0_done",       oLoadDone, 1'b1);
      chk("ld0_done_busy",  oLoadBusy, 1'b1);
      chk("ld0_done_valid", oInstrValid, 1'b0);
      tick();
      chk("ld0_idle_done",  oLoadDone, 1'b0);
      chk("ld0_idle_busy",  oLoadBusy, 1'b0);
      chk("ld0_idle_valid", oInstrValid, 1'b0);
      tick();
      chk("fetch0_valid", oInstrValid, 1'b1);
      chk("fetch0_instr", oInstruction, 28'h0000001);
      iAddress = 16'd1;
      tick();
      chk("fetch1_instr", oInstruction, 28'h0000FA0);
      chk("ld0_done_pulses", done_cnt - d0, 1);

      // Surplus top bits of the first byte are dropped
      start_load(16'd2, 16'd1);
      send_word(32'hF3123456);
      tick(); tick();
      iAddress = 16'd2;
      tick();
      chk("fetch2_instr", oInstruction, 28'h3123456);

      // Load running off the top of memory
      d0 = done_cnt;
      start_load(16'd255, 16'd2);
      send_word(32'h0ABBCCDD);
      send_word(32'h11223344);
      chk("ovf_done",  oLoadDone, 1'b1);
      chk("ovf_error", oLoadError, 1'b1);
      tick(); tick();
      chk("ovf_error_sticky", oLoadError, 1'b1);
      chk("ovf_done_pulses", done_cnt - d0, 1);
      iAddress = 16'd255;
      tick();
      chk("fetch255_instr", oInstruction, 28'hABBCCDD);
      iAddress = 16'd0;
      tick();
      chk("fetch0_after_ovf", oInstruction, 28'h0000001);
      iAddress = 16'd256;
      tick();
      chk("fetch256_instr", oInstruction, EXP_DEFAULT);

      // Zero-count load goes straight to DONE
      d0 = done_cnt;
      start_load(16'd7, 16'd0);
      chk("zero_busy",  oLoadBusy, 1'b1);
      chk("zero_done",  oLoadDone, 1'b1);
      chk("zero_ready", oLoadReady, 1'b0);
      tick(); tick();
      chk("zero_done_pulses", done_cnt - d0, 1);

      // Reset in the middle of a word
      start_load(16'd10, 16'd4);
      chk("rst_ld_error_cleared", oLoadError, 1'b0);
      send_byte(8'h12);
      send_byte(8'h34);
      Reset = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      tick();
      Reset = 1'b1;
      iAddress = 16'd1;
      tick();
      chk("midrst_valid", oInstrValid, 1'b1);
      chk("midrst_fetch1", oInstruction, 28'h0000FA0);
      iAddress = 16'd255;
      tick();
      chk("midrst_fetch255", oInstruction, 28'hABBCCDD);

      // Fresh load after reset must start from byte 0
      iAddress = 16'd1;
      start_load(16'd3, 16'd1);
      chk("busy_fetch_valid", oInstrValid, 1'b0);
      chk("busy_fetch_instr", oInstruction, EXP_DEFAULT);
      send_word(32'h00000007);
      tick(); tick();
      iAddress = 16'd3;
      tick();
      chk("fetch3_instr", oInstruction, 28'h0000007);

`ifdef IRAM_PARITY_EN
      start_load(16'd5, 16'd1);
      send_word(32'h01234567);
      tick(); tick();
      iAddress = 16'd5;
      tick();
      chk("par_clean_instr", oInstruction, 28'h1234567);
      chk("par_clean_err", oParityError, 1'b0);
      dut.u_array.mem_q[5][0] = ~dut.u_array.mem_q[5][0];
      tick();
      chk("par_flip_err", oParityError, 1'b1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_instruction_ram
`default_nettype wire
